// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//
// Upstream command framer for the crypto coprocessor controller. A host
// hands over one whole-register read or write per valid/ready handshake;
// the sequencer turns it into a header word followed by payload words on
// the 32-bit instruct stream. For reads, it collects the controller's
// ctrl_out words into a single 256-bit response.
//
// Ports:
//   clock      in   1    system clock, rising edge
//   reset_n    in   1    asynchronous active-low reset
//   cmd_valid  in   1    host command valid
//   cmd_ready  out  1    sequencer can accept a command (high only in IDLE)
//   cmd_write  in   1    1 = write, 0 = read
//   cmd_reg    in   4    target register index
//   cmd_data   in   256  write payload, word k at [32k+31:32k]
//   instruct   out  32   word stream to the controller
//   ctrl_out   in   32   read word stream from the controller
//   rsp_valid  out  1    one-cycle pulse marking read data complete
//   rsp_reg    out  4    register index of the response
//   rsp_data   out  256  assembled read data
//   busy       out  1    high in every state except IDLE
//
// HDR_HOLD must be at least 1; RD_LAT and GAP may be 0 to skip their phase.

module instruction_sequencer #(
    parameter int HDR_HOLD = 2,
    parameter int RD_LAT   = 2,
    parameter int GAP      = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_write,
    input  logic [3:0]   cmd_reg,
    input  logic [255:0] cmd_data,
    output logic [31:0]  instruct,
    input  logic [31:0]  ctrl_out,
    output logic         rsp_valid,
    output logic [3:0]   rsp_reg,
    output logic [255:0] rsp_data,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WDATA,
        S_RWAIT,
        S_RCAP,
        S_GAP
    } state_t;

    // Terminal counts for the fixed-length phases. A phase of length 0 is
    // never entered, so its terminal count is simply unused.
    localparam logic [7:0] HDR_LAST = 8'(HDR_HOLD - 1);
    localparam logic [7:0] RD_LAST  = 8'(RD_LAT - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    // Where to go once the last payload word has been sent or captured.
    localparam state_t AFTER_XFER = (GAP == 0) ? S_IDLE : S_GAP;

    state_t         state;
    state_t         next_state;
    logic [7:0]     cnt;
    logic           accept;
    logic           wr_flag;
    logic [3:0]     reg_idx;
    logic [255:0]   wr_data;
    logic [2:0]     n_last;

    // Register index -> number of 32-bit words minus one.
    function automatic logic [2:0] words_minus_one(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd8, 4'd9: words_minus_one = 3'd3;
            4'd4, 4'd5, 4'd6:             words_minus_one = 3'd7;
            4'd12, 4'd13, 4'd14:          words_minus_one = 3'd4;
            default:                      words_minus_one = 3'd0;
        endcase
    endfunction

    // Next-state and output decode. cnt counts cycles spent in the current
    // state; each phase ends when cnt reaches its terminal count.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        instruct   = '0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    next_state = S_HDR;
                end
            end
            S_HDR: begin
                instruct = {wr_flag, 27'b0, reg_idx};
                if (cnt == HDR_LAST) begin
                    if (wr_flag)
                        next_state = S_WDATA;
                    else if (RD_LAT == 0)
                        next_state = S_RCAP;
                    else
                        next_state = S_RWAIT;
                end
            end
            S_WDATA: begin
                instruct = wr_data[{cnt[2:0], 5'b00000} +: 32];
                if (cnt == {5'b00000, n_last})
                    next_state = AFTER_XFER;
            end
            S_RWAIT: begin
                if (cnt == RD_LAST)
                    next_state = S_RCAP;
            end
            S_RCAP: begin
                if (cnt == {5'b00000, n_last})
                    next_state = AFTER_XFER;
            end
            S_GAP: begin
                if (cnt == GAP_LAST)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State, phase counter, latched command and response registers.
    // The response is cleared only when a read is accepted, so a write in
    // between leaves the previous read result visible to the host.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wr_flag   <= 1'b0;
            reg_idx   <= '0;
            wr_data   <= '0;
            n_last    <= '0;
            rsp_valid <= 1'b0;
            rsp_reg   <= '0;
            rsp_data  <= '0;
        end else begin
            state     <= next_state;
            cnt       <= (next_state != state) ? 8'd0 : cnt + 8'd1;
            rsp_valid <= (state == S_RCAP) && (cnt == {5'b00000, n_last});
            if (accept) begin
                wr_flag <= cmd_write;
                reg_idx <= cmd_reg;
                wr_data <= cmd_data;
                n_last  <= words_minus_one(cmd_reg);
                if (!cmd_write) begin
                    rsp_reg  <= cmd_reg;
                    rsp_data <= '0;
                end
            end
            if (state == S_RCAP)
                rsp_data[{cnt[2:0], 5'b00000} +: 32] <= ctrl_out;
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed testbench for instruction_sequencer. A default-parameter instance
// (a) and a fast instance with HDR_HOLD=1, RD_LAT=0, GAP=0 (b) share the
// clock, reset and data inputs; each has its own cmd_valid so only the
// addressed instance ever accepts a command.

module tb_instruction_sequencer;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         valid_a, valid_b;
    logic         cmd_write;
    logic [3:0]   cmd_reg;
    logic [255:0] cmd_data;
    logic [31:0]  ctrl_out;

    logic         ready_a, rv_a, busy_a;
    logic [31:0]  ins_a;
    logic [3:0]   rreg_a;
    logic [255:0] rdata_a;

    logic         ready_b, rv_b, busy_b;
    logic [31:0]  ins_b;
    logic [3:0]   rreg_b;
    logic [255:0] rdata_b;

    int checks = 0;
    int errors = 0;

    logic [255:0] dflt_data;
    logic [255:0] words;
    logic [255:0] exp_rsp;

    always #5 clock = ~clock;

    instruction_sequencer dut_a (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(valid_a), .cmd_ready(ready_a),
        .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .instruct(ins_a), .ctrl_out(ctrl_out),
        .rsp_valid(rv_a), .rsp_reg(rreg_a), .rsp_data(rdata_a),
        .busy(busy_a)
    );

    instruction_sequencer #(.HDR_HOLD(1), .RD_LAT(0), .GAP(0)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(valid_b), .cmd_ready(ready_b),
        .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .instruct(ins_b), .ctrl_out(ctrl_out),
        .rsp_valid(rv_b), .rsp_reg(rreg_b), .rsp_data(rdata_b),
        .busy(busy_b)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [255:0] obs,
                               input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_words(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd8, 4'd9: return 4;
            4'd4, 4'd5, 4'd6:             return 8;
            4'd12, 4'd13, 4'd14:          return 5;
            default:                      return 1;
        endcase
    endfunction

    // Runs one command from an IDLE negedge to the negedge on which the
    // selected instance is back in IDLE. Cycle j is the cycle after the
    // j-th edge following acceptance. Every cycle the instruct word,
    // cmd_ready, busy and rsp_valid are compared against the phase model.
    // With hold_valid, cmd_valid stays high and the other command fields
    // are scrambled while busy so any use of them shows up on instruct.
    // Length counts the accept cycle plus every cycle cmd_ready was low.
    task automatic applyStimulus(input bit fast, input bit write,
                                 input logic [3:0] rg, input logic [255:0] data,
                                 input logic [255:0] rd_words, input bit hold_valid);
        int h, r, g, n, done_j, len, rsp_j;
        logic [31:0]  exp_ins;
        logic [255:0] exp_data;
        h = fast ? 1 : 2;
        r = fast ? 0 : 2;
        g = fast ? 0 : 2;
        n = exp_words(rg);
        done_j = write ? h + n + g : h + r + n + g;
        rsp_j  = h + r + n;
        exp_data = '0;
        for (int k = 0; k < n; k++)
            exp_data[32*k +: 32] = rd_words[32*k +: 32];

        checkOutput("ready_before_accept", fast ? ready_b : ready_a, 1'b1);
        cmd_write = write;
        cmd_reg   = rg;
        cmd_data  = data;
        if (fast) valid_b = 1'b1; else valid_a = 1'b1;
        ctrl_out  = 32'hDEAD_BEEF;
        len = 1;
        for (int j = 0; j <= done_j; j++) begin
            @(negedge clock);
            if (j < h)
                exp_ins = {write, 27'b0, rg};
            else if (write && j < h + n)
                exp_ins = data[32*(j-h) +: 32];
            else
                exp_ins = 32'h0;
            checkOutput("instruct", fast ? ins_b : ins_a, exp_ins);
            checkOutput("cmd_ready", fast ? ready_b : ready_a, j == done_j);
            checkOutput("busy", fast ? busy_b : busy_a, j != done_j);
            checkOutput("rsp_valid", fast ? rv_b : rv_a, !write && j == rsp_j);
            if (!write && j == rsp_j) begin
                checkOutput("rsp_reg", fast ? rreg_b : rreg_a, rg);
                checkOutput("rsp_data", fast ? rdata_b : rdata_a, exp_data);
            end
            if (!(fast ? ready_b : ready_a))
                len++;
            if (!write && j >= h + r && j < h + r + n)
                ctrl_out = rd_words[32*(j-h-r) +: 32];
            else
                ctrl_out = 32'hDEAD_0000 | j;
            if (j < done_j) begin
                if (hold_valid) begin
                    cmd_write = ~write;
                    cmd_reg   = ~rg;
                    cmd_data  = ~data;
                end else begin
                    valid_a = 1'b0;
                    valid_b = 1'b0;
                end
            end
        end
        checkOutput("length", len, write ? 1 + h + n + g : 1 + h + r + n + g);
    endtask

    initial begin
        reset_n   = 1'b0;
        valid_a   = 1'b0;
        valid_b   = 1'b0;
        cmd_write = 1'b0;
        cmd_reg   = '0;
        cmd_data  = '0;
        ctrl_out  = '0;
        for (int k = 0; k < 8; k++)
            dflt_data[32*k +: 32] = 32'h1111_1111 * (k + 1);

        // Reset values
        repeat (2) @(negedge clock);
        checkOutput("rst_ready", ready_a, 1'b1);
        checkOutput("rst_instruct", ins_a, 32'h0);
        checkOutput("rst_rsp_valid", rv_a, 1'b0);
        checkOutput("rst_rsp_reg", rreg_a, 4'h0);
        checkOutput("rst_rsp_data", rdata_a, 256'h0);
        checkOutput("rst_busy", busy_a, 1'b0);
        checkOutput("rst_ready_b", ready_b, 1'b1);
        reset_n = 1'b1;
        @(negedge clock);

        // Write reg 4: 8 words
        applyStimulus(1'b0, 1'b1, 4'd4, dflt_data, 256'h0, 1'b0);
        @(negedge clock);

        // Read reg 12: 5 words 0xA0..0xA4
        words = '0;
        for (int k = 0; k < 5; k++) words[32*k +: 32] = 32'hA0 + k;
        applyStimulus(1'b0, 1'b0, 4'd12, 256'h0, words, 1'b0);
        exp_rsp = {96'h0, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
        checkOutput("reg12_hold_data", rdata_a, exp_rsp);

        // 8-word read then 1-word read: no stale upper words
        for (int k = 0; k < 8; k++) words[32*k +: 32] = $urandom;
        applyStimulus(1'b0, 1'b0, 4'd5, 256'h0, words, 1'b0);
        words = '0;
        words[31:0] = 32'hC0FF_EE03;
        words[63:32] = 32'h5555_AAAA;
        applyStimulus(1'b0, 1'b0, 4'd3, 256'h0, words, 1'b0);
        checkOutput("reg3_data", rdata_a, {224'h0, 32'hC0FF_EE03});

        // Back-to-back alternating write/read of reg 0 with cmd_valid held
        applyStimulus(1'b0, 1'b1, 4'd0, {128'h0, 128'h4444_0004_3333_0003_2222_0002_1111_0001},
                      256'h0, 1'b1);
        checkOutput("hold_across_write_data", rdata_a, {224'h0, 32'hC0FF_EE03});
        checkOutput("hold_across_write_reg", rreg_a, 4'd3);
        words = {128'h0, 128'hD3D3_D3D3_D2D2_D2D2_D1D1_D1D1_D0D0_D0D0};
        applyStimulus(1'b0, 1'b0, 4'd0, 256'h0, words, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'd0, {128'h0, 128'h8888_0008_7777_0007_6666_0006_5555_0005},
                      256'h0, 1'b1);
        words = {128'h0, 128'hE3E3_E3E3_E2E2_E2E2_E1E1_E1E1_E0E0_E0E0};
        applyStimulus(1'b0, 1'b0, 4'd0, 256'h0, words, 1'b0);
        @(negedge clock);

        // Reset asserted while WDATA word 2 is on instruct
        cmd_write = 1'b1;
        cmd_reg   = 4'd4;
        cmd_data  = dflt_data;
        valid_a   = 1'b1;
        @(negedge clock);
        valid_a = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("pre_reset_word2", ins_a, 32'h3333_3333);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_instruct", ins_a, 32'h0);
        checkOutput("async_rst_ready", ready_a, 1'b1);
        checkOutput("async_rst_busy", busy_a, 1'b0);
        checkOutput("async_rst_rsp_valid", rv_a, 1'b0);
        checkOutput("async_rst_rsp_data", rdata_a, 256'h0);
        checkOutput("async_rst_rsp_reg", rreg_a, 4'h0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clock);
            checkOutput("post_rst_no_rsp", rv_a, 1'b0);
            checkOutput("post_rst_idle_instruct", ins_a, 32'h0);
        end

        // First command after reset is framed from its header
        words = {128'h0, 128'h0F0F_0F03_0F0F_0F02_0F0F_0F01_0F0F_0F00};
        applyStimulus(1'b0, 1'b0, 4'd0, 256'h0, words, 1'b0);
        @(negedge clock);

        // Fast instance: read reg 9, capture right after the single header
        words = {128'h0, 128'hB3B3_0003_B2B2_0002_B1B1_0001_B0B0_0000};
        applyStimulus(1'b1, 1'b0, 4'd9, 256'h0, words, 1'b0);
        checkOutput("fast_b_a_untouched", rreg_a, 4'd0);
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
